// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the 8x32 register file write port.
// Accepts memory and ALU results (memory is older), buffers them in order,
// drains one per cycle onto ds1/regWrite/wData and publishes a pending
// bitmap so the read side can stall on in-flight writes.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [2:0]    mem_dst,
  input  logic [31:0]   mem_data,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [2:0]    alu_dst,
  input  logic [31:0]   alu_data,
  input  logic          flush,
  output logic [2:0]    ds1,
  output logic          regWrite,
  output logic [31:0]   wData,
  output logic [7:0]    pending,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [2:0]  dst;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t       fifo [DEPTH];
  logic [PW-1:0]   head, tail, alu_slot;
  logic [CW-1:0]   count_plus_mem;
  logic            mem_push, alu_push, pop;

  // Readies look only at the registered count; a same-cycle pop never makes room.
  assign count_plus_mem = count + CW'(mem_valid);
  assign mem_ready      = reset & ~flush & (count < FULL);
  assign alu_ready      = reset & ~flush & (count_plus_mem < FULL);
  assign mem_push       = mem_valid & mem_ready;
  assign alu_push       = alu_valid & alu_ready;
  assign pop            = ~flush & (count != '0);
  // Memory result is older, so it takes the tail and the ALU result follows it.
  assign alu_slot       = tail + PW'(mem_push);

  // Entry storage; contents are only meaningful under count, so no reset needed.
  always_ff @(posedge clk) begin
    if (mem_push) fifo[tail]     <= '{dst: mem_dst, data: mem_data};
    if (alu_push) fifo[alu_slot] <= '{dst: alu_dst, data: alu_data};
  end

  // Pointers, occupancy and the registered write-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      regWrite <= 1'b0;
      ds1      <= '0;
      wData    <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      regWrite <= 1'b0;
    end else begin
      if (pop) begin
        ds1   <= fifo[head].dst;
        wData <= fifo[head].data;
        head  <= head + PW'(1);
      end
      regWrite <= pop;
      tail     <= tail + PW'(mem_push) + PW'(alu_push);
      count    <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  // Pending bitmap: every occupied slot plus the write currently presented.
  always_comb begin
    logic [PW-1:0] off;
    pending = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < count) pending[fifo[i].dst] = 1'b1;
    end
    if (regWrite) pending[ds1] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed scenarios plus a random soak,
// all checked against a queue-based reference model.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk, reset;
  logic          mem_valid, mem_ready, alu_valid, alu_ready, flush;
  logic [2:0]    mem_dst, alu_dst, ds1;
  logic [31:0]   mem_data, alu_data, wData;
  logic          regWrite;
  logic [7:0]    pending;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: in-order list of {dst,data} and the presented write
  logic [34:0] mq[$];
  logic        m_rw;
  logic [2:0]  m_ds1;
  logic [31:0] m_wd;

  regfile_writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .flush(flush), .ds1(ds1), .regWrite(regWrite), .wData(wData),
    .pending(pending), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic m_mrdy();
    return reset && !flush && (mq.size() < DEPTH);
  endfunction

  function automatic logic m_ardy();
    return reset && !flush && (mq.size() + int'(mem_valid) < DEPTH);
  endfunction

  function automatic logic [7:0] m_pend();
    logic [7:0] p = 8'h00;
    foreach (mq[i]) p[mq[i][34:32]] = 1'b1;
    if (m_rw) p[m_ds1] = 1'b1;
    return p;
  endfunction

  task automatic drive(input logic mv, input logic [2:0] md, input logic [31:0] mdat,
                       input logic av, input logic [2:0] ad, input logic [31:0] adat,
                       input logic fl);
    mem_valid = mv; mem_dst = md; mem_data = mdat;
    alu_valid = av; alu_dst = ad; alu_data = adat;
    flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  // Advance one rising edge and update the model with the same rules.
  task automatic step();
    logic am, aa;
    logic [34:0] e;
    am = mem_valid && m_mrdy();
    aa = alu_valid && m_ardy();
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_rw = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_rw = 1'b1; m_ds1 = e[34:32]; m_wd = e[31:0];
      end else m_rw = 1'b0;
      if (am) mq.push_back({mem_dst, mem_data});
      if (aa) mq.push_back({alu_dst, alu_data});
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle();
    mq.delete(); m_rw = 1'b0; m_ds1 = 3'd0; m_wd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regWrite: got %b want 0", regWrite); end
    n_tests++; if (ds1 !== 3'd0 || wData !== 32'd0) begin n_fail++; $display("FAIL reset_port: got ds1=%0d wData=%h want 0/0", ds1, wData); end
    n_tests++; if (pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h want 00", pending); end
    n_tests++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", mem_ready, alu_ready); end
    reset = 1'b1;
    #1;
    n_tests++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b%b want 11", mem_ready, alu_ready); end
  endtask

  task automatic test_single();
    drive(1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0, 1'b0);
    #1;
    n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", mem_ready); end
    step(); idle();
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    n_tests++; if (pending !== 8'h20) begin n_fail++; $display("FAIL single_pending: got %h want 20", pending); end
    n_tests++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL single_early_write: got %b want 0", regWrite); end
    step();
    n_tests++; if (regWrite !== 1'b1 || ds1 !== 3'd5 || wData !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL single_present: got rw=%b ds1=%0d wData=%h want 1/5/deadbeef", regWrite, ds1, wData); end
    n_tests++; if (pending !== 8'h20 || count !== 3'd0) begin n_fail++; $display("FAIL single_inflight: got pend=%h cnt=%0d want 20/0", pending, count); end
    step();
    n_tests++; if (regWrite !== 1'b0 || pending !== 8'h00 || wData !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL single_done: got rw=%b pend=%h wData=%h want 0/00/deadbeef", regWrite, pending, wData); end
  endtask

  task automatic test_dual();
    drive(1'b1, 3'd2, 32'h11, 1'b1, 3'd2, 32'h22, 1'b0);
    #1;
    n_tests++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL dual_ready: got %b%b want 11", mem_ready, alu_ready); end
    step(); idle();
    n_tests++; if (count !== 3'd2 || pending !== 8'h04) begin n_fail++; $display("FAIL dual_count: got cnt=%0d pend=%h want 2/04", count, pending); end
    step();
    n_tests++; if (regWrite !== 1'b1 || ds1 !== 3'd2 || wData !== 32'h11 || pending !== 8'h04)
      begin n_fail++; $display("FAIL dual_first: got rw=%b ds1=%0d wData=%h pend=%h want 1/2/11/04", regWrite, ds1, wData, pending); end
    step();
    n_tests++; if (regWrite !== 1'b1 || wData !== 32'h22 || pending !== 8'h04 || count !== 3'd0)
      begin n_fail++; $display("FAIL dual_second: got rw=%b wData=%h pend=%h cnt=%0d want 1/22/04/0", regWrite, wData, pending, count); end
    step();
    n_tests++; if (regWrite !== 1'b0 || pending !== 8'h00) begin n_fail++; $display("FAIL dual_done: got rw=%b pend=%h want 0/00", regWrite, pending); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), $urandom, 1'b1, 3'($urandom_range(0, 7)), $urandom, 1'b0);
      #1;
      if (mq.size() == 3) begin
        n_tests++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0)
          begin n_fail++; $display("FAIL fill_cnt3_ready: got %b%b want 10", mem_ready, alu_ready); end
      end
      n_tests++; if (mem_ready !== m_mrdy() || alu_ready !== m_ardy())
        begin n_fail++; $display("FAIL fill_ready: got %b%b want %b%b", mem_ready, alu_ready, m_mrdy(), m_ardy()); end
      step();
      n_tests++; if (regWrite !== m_rw || (m_rw && (ds1 !== m_ds1 || wData !== m_wd)))
        begin n_fail++; $display("FAIL fill_data: got rw=%b ds1=%0d wData=%h want %b/%0d/%h", regWrite, ds1, wData, m_rw, m_ds1, m_wd); end
    end
    // at count 3 a lone ALU request still fits
    drive(1'b0, 3'd0, 32'd0, 1'b1, 3'd6, 32'h66, 1'b0);
    #1;
    n_tests++; if (count !== 3'd3 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL fill_alu_only: got cnt=%0d ardy=%b want 3/1", count, alu_ready); end
    step(); idle();
    for (int c = 0; c < 6; c++) begin
      step();
      n_tests++; if (regWrite !== m_rw || (m_rw && (ds1 !== m_ds1 || wData !== m_wd)) || count !== CW'(mq.size()))
        begin n_fail++; $display("FAIL fill_drain: got rw=%b ds1=%0d wData=%h cnt=%0d want %b/%0d/%h/%0d", regWrite, ds1, wData, count, m_rw, m_ds1, m_wd, mq.size()); end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 3'd1, 32'hA1, 1'b1, 3'd3, 32'hA3, 1'b0); step();
    drive(1'b1, 3'd4, 32'hA4, 1'b1, 3'd7, 32'hA7, 1'b0); step();
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_setup: got cnt=%0d want 3", count); end
    drive(1'b1, 3'd0, 32'hB0, 1'b1, 3'd6, 32'hB6, 1'b1);
    #1;
    n_tests++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b%b want 00", mem_ready, alu_ready); end
    step(); idle();
    n_tests++; if (count !== 3'd0 || regWrite !== 1'b0 || pending !== 8'h00)
      begin n_fail++; $display("FAIL flush_empty: got cnt=%0d rw=%b pend=%h want 0/0/00", count, regWrite, pending); end
    step();
    n_tests++; if (count !== 3'd0 || regWrite !== 1'b0) begin n_fail++; $display("FAIL flush_noaccept: got cnt=%0d rw=%b want 0/0", count, regWrite); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'd3, 32'hC3, 1'b1, 3'd5, 32'hC5, 1'b0); step(); idle(); step();
    n_tests++; if (regWrite !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL areset_setup: got rw=%b cnt=%0d want 1/1", regWrite, count); end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (regWrite !== 1'b0 || count !== 3'd0 || pending !== 8'h00)
      begin n_fail++; $display("FAIL areset_clear: got rw=%b cnt=%0d pend=%h want 0/0/00", regWrite, count, pending); end
    mq.delete(); m_rw = 1'b0; m_ds1 = 3'd0; m_wd = 32'd0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_soak();
    int max_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 49) == 0);
      #1;
      n_tests++; if (mem_ready !== m_mrdy() || alu_ready !== m_ardy())
        begin n_fail++; $display("FAIL soak_ready c=%0d: got %b%b want %b%b", c, mem_ready, alu_ready, m_mrdy(), m_ardy()); end
      n_tests++; if (pending !== m_pend() || count !== CW'(mq.size()))
        begin n_fail++; $display("FAIL soak_state c=%0d: got pend=%h cnt=%0d want %h/%0d", c, pending, count, m_pend(), mq.size()); end
      step();
      n_tests++; if (regWrite !== m_rw || (m_rw && (ds1 !== m_ds1 || wData !== m_wd)))
        begin n_fail++; $display("FAIL soak_write c=%0d: got rw=%b ds1=%0d wData=%h want %b/%0d/%h", c, regWrite, ds1, wData, m_rw, m_ds1, m_wd); end
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    n_tests++; if (max_cnt > DEPTH) begin n_fail++; $display("FAIL soak_bound: got max count %0d want <= %0d", max_cnt, DEPTH); end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_fill();
    test_flush();
    test_async_reset();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side companion to the 8 x 32-bit register file. It collects writeback results from the ALU and memory pipeline stages through valid/ready handshakes and buffers them in a small in-order FIFO. It drains one entry per cycle onto the register file's single write port (`ds1`, `regWrite`, `wData`). It also publishes a per-register pending bitmap, which the decode/read side uses to stall reads of registers whose writes are still in flight.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `CW`, default 3: width of `count`, equal to log2(DEPTH)+1.

Ports:
- `clk`, input, 1: single clock. State updates on the rising edge; the register file captures on the falling edge.
- `reset`, input, 1: asynchronous, active-low. `reset`=0 clears all state immediately.
- `mem_valid`, input, 1: memory-stage writeback request.
- `mem_ready`, output, 1: memory request accepted this cycle when high together with `mem_valid`.
- `mem_dst`, input, 3: destination register of the memory request.
- `mem_data`, input, 32: write data of the memory request.
- `alu_valid`, input, 1: ALU-stage writeback request.
- `alu_ready`, output, 1: ALU request accepted this cycle when high together with `alu_valid`.
- `alu_dst`, input, 3: destination register of the ALU request.
- `alu_data`, input, 32: write data of the ALU request.
- `flush`, input, 1: synchronous discard of all queued writes.
- `ds1`, output, 3: register-file write address; registered.
- `regWrite`, output, 1: register-file write enable; registered.
- `wData`, output, 32: register-file write data; registered.
- `pending`, output, 8: bit r is high while a write to register r is queued or being presented.
- `count`, output, CW: number of occupied FIFO entries.

## Operation
- Storage is a circular FIFO of {dst[2:0], data[31:0]} with head and tail pointers that wrap modulo DEPTH, plus an occupancy counter.
- Memory results are older than ALU results. On simultaneous acceptance, the memory entry is written at the tail and the ALU entry at tail+1.
- `mem_ready` = reset deasserted, `flush`=0, and `count` < DEPTH.
- `alu_ready` = reset deasserted, `flush`=0, and `count` + (`mem_valid` ? 1 : 0) < DEPTH.
- Readies are computed from the registered `count` only. A pop in the same cycle does not create room.
- Drain: on each rising edge with `count`>0 and `flush`=0, the head entry is popped into the output registers and `regWrite` is set to 1. With `count`=0, `regWrite` is set to 0 and `ds1`/`wData` hold their previous values.
- Next count = count + accepted pushes (0..2) - pop (0..1). It never exceeds DEPTH and never goes negative.
- Register 0 is an ordinary register; no write suppression applies to it.
- `pending` is combinational. Bit r = OR over occupied entries of (dst == r), OR (`regWrite` && `ds1` == r). The presented write counts as pending until the falling edge commits it.
- Duplicate destinations in the queue are legal. They drain in order, so the last-accepted value wins.
- `flush`=1 at a rising edge: the queue empties (`count`=0, pointers reset to 0), `regWrite`=0, and no push or pop happens that cycle. A write presented in the flush cycle still completes at that cycle's falling edge.

## Timing
- Reset values: `count`=0, `regWrite`=0, `ds1`=0, `wData`=0, `pending`=0. `mem_ready` and `alu_ready` are 0 while `reset`=0 and 1 in the first cycle after release.
- Latency: an entry accepted at rising edge N into an empty queue appears on `ds1`/`regWrite`/`wData` after rising edge N+1. The register file commits it at the falling edge within cycle N+1.
- Throughput: one register write per cycle. A sustained dual push fills the queue at a net +1 per cycle.
- Reset asserted mid-operation: the queue contents are lost and `regWrite` drops immediately without waiting for a clock edge.
- Outputs `ds1`, `regWrite`, and `wData` are glitch-free because they come directly from flops.

## Test plan
- Reset release, then a single memory request {dst=5, data=32'hDEADBEEF}: `mem_ready`=1. After one edge `count`=1 and `pending`=8'h20. The next edge presents `regWrite`=1, `ds1`=5, `wData`=32'hDEADBEEF. `pending` clears one cycle later.
- Simultaneous mem {dst=2, 32'h11} and alu {dst=2, 32'h22} into an empty queue: both accepted and `count`=2. Writes are presented in the order 32'h11 then 32'h22 on consecutive cycles, and `pending[2]` stays high until the second write is committed.
- Fill with DEPTH=4 while the drain runs: with `count`=3 and both valid, only mem is accepted (`alu_ready`=0). With `count`=4, both readies are 0. Queue data is intact after the head and tail pointers wrap.
- `flush` pulse with `count`=3: `count`=0 next edge, `regWrite`=0, `pending`=0, and requests presented in the flush cycle are not accepted.
- Assert `reset`=0 asynchronously between clock edges with `regWrite`=1: `regWrite`, `count`, and `pending` go to 0 without a clock edge.
- Random push/drain soak of 1000 cycles against a reference queue model: the order and values of `ds1`/`wData` match, and `count` stays within 0..4.
